// File: rtl/onehot_rr_arbiter_if.sv
// Handshake bundle between the requester bank and the round-robin arbiter.
interface onehot_rr_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    // Requester bank side: drives requests and the release strobe.
    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Eight-way round-robin arbiter with hold-until-release grants and a
// watchdog that forces a release after TIMEOUT cycles (0 disables it).
module onehot_rr_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    onehot_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [2:0]        last;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        grant_q;
    logic [2:0]        idx_q;
    logic              valid_q;
    logic              timeout_q;

    logic              pick_found;
    logic [2:0]        pick_idx;
    logic [2:0]        cand;
    logic              user_rel;
    logic              wd_hit;

    // Round-robin pick: first requesting index after the last owner, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Release causes seen while a grant is held.
    always_comb begin
        user_rel = bus.done || !bus.req[idx_q];
        wd_hit   = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    end

    // Arbitration FSM with registered grant, index, valid and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 3'd7;
            cnt       <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (pick_found) begin
                        grant_q <= 8'b1 << pick_idx;
                        idx_q   <= pick_idx;
                        valid_q <= 1'b1;
                        last    <= pick_idx;
                        cnt     <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (user_rel || wd_hit) begin
                        // Pulse only when the watchdog alone caused the release.
                        timeout_q <= wd_hit && !user_rel;
                        grant_q   <= '0;
                        idx_q     <= '0;
                        valid_q   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        timeout_q <= 1'b0;
                        if (cnt != '1) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench for onehot_rr_arbiter: directed vector table, then
// randomized traffic against a behavioural reference model.
module tb_onehot_rr_arbiter;

    localparam int TO = 4;

    logic clk;
    logic rst;

    onehot_rr_arbiter_if bus ();

    onehot_rr_arbiter #(
        .TIMEOUT(TO),
        .CNT_W  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       rst;
        logic [7:0] exp_grant;
        logic [2:0] exp_idx;
        logic       exp_valid;
        logic       exp_tout;
    } vec_t;

    vec_t vecs[$];

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state: owner index (-1 when idle), last owner,
    // cycles the current grant has been visible, pending timeout flag.
    int m_owner = -1;
    int m_last  = 7;
    int m_held  = 0;
    bit m_tout  = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] r, input logic d, input logic x);
        bit drop;
        bit wd;
        int c;
        if (x) begin
            m_owner = -1;
            m_last  = 7;
            m_held  = 0;
            m_tout  = 1'b0;
        end else if (m_owner < 0) begin
            m_tout = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                c = (m_last + k) % 8;
                if (r[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                    break;
                end
            end
        end else begin
            drop = d || !r[m_owner];
            wd   = (TO != 0) && (m_held == TO);
            if (drop || wd) begin
                m_tout  = wd && !drop;
                m_owner = -1;
            end else begin
                m_held++;
                m_tout = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic d, input logic x);
        bus.req  = r;
        bus.done = d;
        rst      = x;
        @(posedge clk);
        model_step(r, d, x);
        #2;
    endtask

    function automatic void add(input logic [7:0] r, input logic d, input logic x,
                                input logic [7:0] g, input logic [2:0] i,
                                input logic v, input logic t);
        vec_t e;
        e.req = r; e.done = d; e.rst = x;
        e.exp_grant = g; e.exp_idx = i; e.exp_valid = v; e.exp_tout = t;
        vecs.push_back(e);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] r;
        logic       d;
        logic       x;
        logic [7:0] exp_g;

        bus.req  = '0;
        bus.done = 1'b0;
        rst      = 1'b1;

        // Single requester, release by done.
        add(8'h00, 0, 1, 8'h00, 3'd0, 0, 0);
        add(8'h04, 0, 0, 8'h04, 3'd2, 1, 0);
        add(8'h04, 1, 0, 8'h00, 3'd0, 0, 0);
        add(8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
        // All requesting, done on every grant: 0..7 then wrap to 0.
        add(8'hFF, 0, 1, 8'h00, 3'd0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            add(8'hFF, 0, 0, 8'(1 << (i % 8)), 3'(i % 8), 1, 0);
            add(8'hFF, 1, 0, 8'h00, 3'd0, 0, 0);
        end
        // Two requesters at the ends: 0, 7, 0.
        add(8'h81, 0, 1, 8'h00, 3'd0, 0, 0);
        add(8'h81, 0, 0, 8'h01, 3'd0, 1, 0);
        add(8'h81, 1, 0, 8'h00, 3'd0, 0, 0);
        add(8'h81, 0, 0, 8'h80, 3'd7, 1, 0);
        add(8'h81, 1, 0, 8'h00, 3'd0, 0, 0);
        add(8'h81, 0, 0, 8'h01, 3'd0, 1, 0);
        add(8'h81, 1, 0, 8'h00, 3'd0, 0, 0);
        // Watchdog: grant visible exactly TO cycles, then timeout pulse.
        add(8'h10, 0, 0, 8'h10, 3'd4, 1, 0);
        add(8'h10, 0, 0, 8'h10, 3'd4, 1, 0);
        add(8'h10, 0, 0, 8'h10, 3'd4, 1, 0);
        add(8'h10, 0, 0, 8'h10, 3'd4, 1, 0);
        add(8'h10, 0, 0, 8'h00, 3'd0, 0, 1);
        add(8'h10, 0, 0, 8'h10, 3'd4, 1, 0);
        add(8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
        // Request drop releases without timeout; done in IDLE ignored.
        add(8'h08, 0, 0, 8'h08, 3'd3, 1, 0);
        add(8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
        add(8'h00, 1, 0, 8'h00, 3'd0, 0, 0);
        add(8'h00, 1, 0, 8'h00, 3'd0, 0, 0);
        // Reset mid-grant, then re-grant.
        add(8'h20, 0, 0, 8'h20, 3'd5, 1, 0);
        add(8'h20, 0, 1, 8'h00, 3'd0, 0, 0);
        add(8'h20, 0, 0, 8'h20, 3'd5, 1, 0);
        // Done coinciding with watchdog expiry: no timeout pulse.
        add(8'h20, 0, 0, 8'h20, 3'd5, 1, 0);
        add(8'h20, 0, 0, 8'h20, 3'd5, 1, 0);
        add(8'h20, 0, 0, 8'h20, 3'd5, 1, 0);
        add(8'h20, 1, 0, 8'h00, 3'd0, 0, 0);
        // Priority restarts at 0 after reset.
        add(8'h21, 0, 1, 8'h00, 3'd0, 0, 0);
        add(8'h21, 0, 0, 8'h01, 3'd0, 1, 0);
        add(8'h21, 1, 0, 8'h00, 3'd0, 0, 0);
        add(8'h21, 0, 0, 8'h20, 3'd5, 1, 0);

        foreach (vecs[n]) begin
            step(vecs[n].req, vecs[n].done, vecs[n].rst);
            check($sformatf("vec%0d_grant", n), bus.grant, vecs[n].exp_grant);
            check($sformatf("vec%0d_idx", n), bus.grant_idx, vecs[n].exp_idx);
            check($sformatf("vec%0d_valid", n), bus.grant_valid, vecs[n].exp_valid);
            check($sformatf("vec%0d_tout", n), bus.timeout, vecs[n].exp_tout);
        end

        r = 8'h00;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0: r = 8'h00;
                    1: r = 8'(1 << $urandom_range(0, 7));
                    default: r = 8'($urandom);
                endcase
            end
            d = ($urandom_range(0, 4) == 0);
            x = ($urandom_range(0, 99) == 0);
            step(r, d, x);
            exp_g = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
            check("rnd_grant", bus.grant, exp_g);
            check("rnd_idx", bus.grant_idx, (m_owner < 0) ? 0 : m_owner);
            check("rnd_valid", bus.grant_valid, (m_owner >= 0) ? 1 : 0);
            check("rnd_tout", bus.timeout, m_tout);
            check("rnd_onehot", ($countones(bus.grant) <= 1) ? 1 : 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
